// File: rtl/text_ram_arbiter.sv
// Single-port char RAM arbiter: display reads win, buffered writes retire in idle slots,
// starved writes are forced through. Optional clear sweep under `TEXT_RAM_CLEAR_EN`.
module text_ram_arbiter #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef TEXT_RAM_CLEAR_EN
    input  logic                          clear_start,
`endif
    input  logic                          disp_req,
    input  logic [ADDR_W-1:0]             disp_addr,
    output logic                          disp_grant,
    output logic [DATA_W-1:0]             disp_rdata,
    output logic                          disp_rvalid,
    output logic                          disp_stall,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StDisp,
        StWr,
        StForce
`ifdef TEXT_RAM_CLEAR_EN
        , StClr
`endif
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic fifo_empty;
    logic force_cond;
    logic push;
    logic pop;
    logic sweep_active;

`ifdef TEXT_RAM_CLEAR_EN
    localparam int unsigned CellCount = 2400;

    logic              clr_active_q, clr_active_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    assign sweep_active = clr_active_q;
`else
    assign sweep_active = 1'b0;
`endif

    assign fifo_empty = (level_q == '0);
    assign force_cond = (cnt_q == CntW'(STARVE_LIMIT)) && !fifo_empty;
    assign wr_ready   = (level_q < LvlW'(FIFO_DEPTH)) && !sweep_active;
    assign push       = wr_valid && wr_ready;
    assign fifo_level = level_q;
    assign busy       = !fifo_empty || sweep_active;

    // A granted read last cycle means its data is on ram_rdata now.
    assign disp_rvalid = (state_q == StDisp);
    assign disp_rdata  = disp_rvalid ? ram_rdata : '0;

    // Port owner: forced write > display read > clear sweep > queued write > idle.
    always_comb begin
        state_d    = StIdle;
        disp_grant = 1'b0;
        disp_stall = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        pop        = 1'b0;
        if (force_cond) begin
            state_d    = StForce;
            disp_stall = disp_req;
            ram_en     = 1'b1;
            ram_we     = 1'b1;
            ram_addr   = fifo_addr_q[rd_ptr_q];
            ram_wdata  = fifo_data_q[rd_ptr_q];
            pop        = 1'b1;
        end else if (disp_req) begin
            state_d    = StDisp;
            disp_grant = 1'b1;
            ram_en     = 1'b1;
            ram_addr   = disp_addr;
`ifdef TEXT_RAM_CLEAR_EN
        end else if (clr_active_q) begin
            state_d    = StClr;
            ram_en     = 1'b1;
            ram_we     = 1'b1;
            ram_addr   = clr_addr_q;
            ram_wdata  = DATA_W'(8'h20);
`endif
        end else if (!fifo_empty) begin
            state_d    = StWr;
            ram_en     = 1'b1;
            ram_we     = 1'b1;
            ram_addr   = fifo_addr_q[rd_ptr_q];
            ram_wdata  = fifo_data_q[rd_ptr_q];
            pop        = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        level_d  = level_q + LvlW'(push) - LvlW'(pop);
        cnt_d    = cnt_q;
        if (pop || fifo_empty) begin
            cnt_d = '0;
        end else if (state_d == StDisp && cnt_q != CntW'(STARVE_LIMIT)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

`ifdef TEXT_RAM_CLEAR_EN
    always_comb begin
        clr_active_d = clr_active_q;
        clr_addr_d   = clr_addr_q;
        if (state_d == StClr) begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == ADDR_W'(CellCount - 1)) begin
                clr_active_d = 1'b0;
            end
        end
        // A new pulse always restarts from address 0; only a forced-write cycle ignores it.
        if (clear_start && (clr_active_q || state_d != StForce)) begin
            clr_active_d = 1'b1;
            clr_addr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_active_q <= 1'b0;
            clr_addr_q   <= '0;
        end else begin
            clr_active_q <= clr_active_d;
            clr_addr_q   <= clr_addr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage needs no reset; the level and pointers qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed bench for text_ram_arbiter with a behavioural 1-cycle-latency char RAM.
// Covers the clear sweep when TEXT_RAM_CLEAR_EN is defined.
module tb_text_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        clear_start;
    logic        disp_req;
    logic [11:0] disp_addr;
    logic        disp_grant;
    logic [7:0]  disp_rdata;
    logic        disp_rvalid;
    logic        disp_stall;
    logic        wr_valid;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [2:0]  fifo_level;
    logic        busy;

    int checks;
    int failures;

    logic [7:0] mem [4096];

    text_ram_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef TEXT_RAM_CLEAR_EN
        .clear_start (clear_start),
`endif
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_grant  (disp_grant),
        .disp_rdata  (disp_rdata),
        .disp_rvalid (disp_rvalid),
        .disp_stall  (disp_stall),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .fifo_level  (fifo_level),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else ram_rdata <= mem[ram_addr];
        end
    end

    task automatic test_reset;
        @(negedge clk);
        #1;
        checks++;
        if ({wr_ready, busy, disp_rvalid, ram_en, disp_grant, disp_stall} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=100000",
                     {wr_ready, busy, disp_rvalid, ram_en, disp_grant, disp_stall});
        end
        checks++;
        if (fifo_level !== 3'd0) begin
            failures++;
            $display("FAIL reset_level got=%0d want=0", fifo_level);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk);
        disp_req  = 1'b1;
        disp_addr = 12'd5;
        #1;
        checks++;
        if (disp_grant !== 1'b1 || ram_addr !== 12'd5 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL midread_grant got=%b/%0d want=1/5", disp_grant, ram_addr);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        disp_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (disp_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL midread_rvalid cycle=%0d got=%b want=0", i, disp_rvalid);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (wr_ready !== 1'b1 || fifo_level !== 3'd0) begin
            failures++;
            $display("FAIL midread_release got=%b/%0d want=1/0", wr_ready, fifo_level);
        end
    endtask

    task automatic test_idle_write;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 12'd100;
        wr_data  = 8'h41;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || ram_en !== 1'b0) begin
            failures++;
            $display("FAIL idlewr_accept got=%b/%b want=1/0", wr_ready, ram_en);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 12'd100, 8'h41}) begin
            failures++;
            $display("FAIL idlewr_ram got=%b%b/%0d/%h want=11/100/41",
                     ram_en, ram_we, ram_addr, ram_wdata);
        end
        checks++;
        if (fifo_level !== 3'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL idlewr_level got=%0d/%b want=1/1", fifo_level, busy);
        end
        @(negedge clk);
        disp_req  = 1'b1;
        disp_addr = 12'd100;
        #1;
        checks++;
        if (fifo_level !== 3'd0 || disp_grant !== 1'b1 || disp_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL idlewr_readreq got=%0d/%b/%b want=0/1/0",
                     fifo_level, disp_grant, disp_rvalid);
        end
        @(negedge clk);
        disp_req = 1'b0;
        #1;
        checks++;
        if (disp_rvalid !== 1'b1 || disp_rdata !== 8'h41) begin
            failures++;
            $display("FAIL idlewr_readback got=%b/%h want=1/41", disp_rvalid, disp_rdata);
        end
    endtask

    // Display holds the port; writes are forced every 16th cycle once the FIFO has data.
    task automatic test_fill_and_starve;
        int         forced;
        logic       f;
        logic [11:0] exp_a;
        logic [7:0]  exp_d;
        forced = 0;
        for (int k = 0; k <= 70; k++) begin
            @(negedge clk);
            disp_req  = 1'b1;
            disp_addr = 12'd0;
            wr_valid  = (k <= 4);
            wr_addr   = 12'(200 + k);
            wr_data   = 8'(8'h50 + k);
            #1;
            f = (k == 16 || k == 32 || k == 48 || k == 64);
            if (k < 4) begin
                checks++;
                if (wr_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL fill_ready k=%0d got=%b want=1", k, wr_ready);
                end
            end
            if (k == 4) begin
                checks++;
                if (wr_ready !== 1'b0 || fifo_level !== 3'd4) begin
                    failures++;
                    $display("FAIL fill_full got=%b/%0d want=0/4", wr_ready, fifo_level);
                end
            end
            if (k == 17) begin
                checks++;
                if (fifo_level !== 3'd3) begin
                    failures++;
                    $display("FAIL starve_level got=%0d want=3", fifo_level);
                end
            end
            checks++;
            if ({disp_stall, disp_grant, ram_we} !== {f, !f, f}) begin
                failures++;
                $display("FAIL starve_owner k=%0d got=%b want=%b",
                         k, {disp_stall, disp_grant, ram_we}, {f, !f, f});
            end
            if (f) begin
                exp_a = 12'(200 + forced);
                exp_d = 8'(8'h50 + forced);
                checks++;
                if (ram_addr !== exp_a || ram_wdata !== exp_d) begin
                    failures++;
                    $display("FAIL starve_head k=%0d got=%0d/%h want=%0d/%h",
                             k, ram_addr, ram_wdata, exp_a, exp_d);
                end
                forced++;
            end
        end
        @(negedge clk);
        disp_req = 1'b0;
        wr_valid = 1'b0;
        #1;
        checks++;
        if (fifo_level !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL starve_drain got=%0d/%b want=0/0", fifo_level, busy);
        end
    endtask

    task automatic test_ordering;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 12'd7;
        wr_data  = 8'h01;
        @(negedge clk);
        wr_data = 8'h02;
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 12'd7 || ram_wdata !== 8'h01) begin
            failures++;
            $display("FAIL order_first got=%b/%0d/%h want=1/7/01", ram_we, ram_addr, ram_wdata);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_wdata !== 8'h02 || fifo_level !== 3'd1) begin
            failures++;
            $display("FAIL order_second got=%b/%h/%0d want=1/02/1", ram_we, ram_wdata, fifo_level);
        end
        @(negedge clk);
        disp_req  = 1'b1;
        disp_addr = 12'd7;
        @(negedge clk);
        disp_req = 1'b0;
        #1;
        checks++;
        if (disp_rvalid !== 1'b1 || disp_rdata !== 8'h02) begin
            failures++;
            $display("FAIL order_final got=%b/%h want=1/02", disp_rvalid, disp_rdata);
        end
    endtask

    // Read racing a queued write to the same cell sees the old value; back-to-back reads.
    task automatic test_back_to_back;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 12'd300;
        wr_data  = 8'h11;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        wr_valid  = 1'b1;
        wr_data   = 8'hAA;
        disp_req  = 1'b1;
        disp_addr = 12'd300;
        @(negedge clk);
        wr_valid  = 1'b0;
        disp_addr = 12'd100;
        #1;
        checks++;
        if (disp_rvalid !== 1'b1 || disp_rdata !== 8'h11) begin
            failures++;
            $display("FAIL nobypass_old got=%b/%h want=1/11", disp_rvalid, disp_rdata);
        end
        @(negedge clk);
        disp_addr = 12'd7;
        #1;
        checks++;
        if (disp_rvalid !== 1'b1 || disp_rdata !== 8'h41) begin
            failures++;
            $display("FAIL b2b_second got=%b/%h want=1/41", disp_rvalid, disp_rdata);
        end
        @(negedge clk);
        disp_req = 1'b0;
        #1;
        checks++;
        if (disp_rvalid !== 1'b1 || disp_rdata !== 8'h02) begin
            failures++;
            $display("FAIL b2b_third got=%b/%h want=1/02", disp_rvalid, disp_rdata);
        end
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 12'd300 || ram_wdata !== 8'hAA) begin
            failures++;
            $display("FAIL nobypass_retire got=%b/%0d/%h want=1/300/aa",
                     ram_we, ram_addr, ram_wdata);
        end
        @(negedge clk);
        disp_req  = 1'b1;
        disp_addr = 12'd300;
        #1;
        checks++;
        if (disp_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL nobypass_gap got=%b want=0", disp_rvalid);
        end
        @(negedge clk);
        disp_req = 1'b0;
        #1;
        checks++;
        if (disp_rvalid !== 1'b1 || disp_rdata !== 8'hAA) begin
            failures++;
            $display("FAIL nobypass_new got=%b/%h want=1/aa", disp_rvalid, disp_rdata);
        end
    endtask

`ifdef TEXT_RAM_CLEAR_EN
    task automatic test_clear_sweep;
        int          writes;
        logic        done;
        logic [11:0] next_a;
        writes = 0;
        done   = 1'b0;
        next_a = 12'd0;
        @(negedge clk);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL clear_start got=%b/%b want=1/0", busy, wr_ready);
        end
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            disp_req  = k[0];
            disp_addr = 12'd1;
            #1;
            if (!busy) begin
                done = 1'b1;
                break;
            end
            if (ram_we) begin
                checks++;
                if ({disp_grant, ram_wdata, ram_addr} !== {1'b0, 8'h20, next_a}) begin
                    failures++;
                    $display("FAIL clear_write got=%b/%h/%0d want=0/20/%0d",
                             disp_grant, ram_wdata, ram_addr, next_a);
                end
                next_a++;
                writes++;
            end
        end
        disp_req = 1'b0;
        checks++;
        if (done !== 1'b1 || writes != 2400) begin
            failures++;
            $display("FAIL clear_count got=%0d/%b want=2400/1", writes, done);
        end
    endtask
`endif

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        clear_start = 1'b0;
        disp_req    = 1'b0;
        disp_addr   = '0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        test_reset();
        test_reset_mid_read();
        test_idle_write();
        test_fill_and_starve();
        test_ordering();
        test_back_to_back();
`ifdef TEXT_RAM_CLEAR_EN
        test_clear_sweep();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
